// File: rtl/pipe_cpu.sv
`timescale 1ns/1ps
// pipe_cpu: four-stage FE/DC/EX/WB pipeline with full operand forwarding,
// branches resolved in EX (two-cycle flush) and a sticky HALT.
module pipe_cpu #(
  parameter int DW  = 16,
  parameter int IAW = 8,
  parameter int DAW = 8
) (
  input  logic           clk,
  input  logic           rst,
  output logic [IAW-1:0] imem_addr,
  input  logic [15:0]    imem_data,
  output logic [DAW-1:0] dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  output logic           dmem_we,
  input  logic [DW-1:0]  dmem_rdata,
  input  logic           stall_in,
  output logic           halted,
  output logic [IAW-1:0] dbg_pc
);

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0, OP_ADD  = 4'h1, OP_SUB = 4'h2, OP_AND  = 4'h3,
    OP_OR     = 4'h4, OP_XOR  = 4'h5, OP_SHL = 4'h6, OP_SHR  = 4'h7,
    OP_LI     = 4'h8, OP_LD   = 4'h9, OP_ST  = 4'hA, OP_BEQZ = 4'hB,
    OP_JMP    = 4'hC, OP_RSV_D = 4'hD, OP_RSV_E = 4'hE, OP_HALT = 4'hF
  } op_e;

  // FE / DC state
  logic [IAW-1:0] pc;
  logic           halted_q;
  logic [15:0]    dc_ir;

  // EX stage
  op_e            ex_op;
  logic [3:0]     ex_rd;
  logic [7:0]     ex_imm;
  logic [DW-1:0]  ex_a, ex_b, ex_c;   // r[rs], r[rt], r[rd]

  // WB stage
  logic           wb_we;
  logic [3:0]     wb_rd;
  logic [DW-1:0]  wb_val;

  logic [DW-1:0]  rf [16];

  logic           ex_wr, take_br, ex_halt, flush;
  logic [DW-1:0]  ex_res;
  logic [3:0]     sh_amt;
  logic [DW-1:0]  dc_a, dc_b, dc_c;

  assign sh_amt = ex_b[3:0];

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    ex_res  = '0;
    ex_wr   = 1'b0;
    take_br = 1'b0;
    ex_halt = 1'b0;
    case (ex_op)
      OP_ADD:  begin ex_res = ex_a + ex_b; ex_wr = 1'b1; end
      OP_SUB:  begin ex_res = ex_a - ex_b; ex_wr = 1'b1; end
      OP_AND:  begin ex_res = ex_a & ex_b; ex_wr = 1'b1; end
      OP_OR:   begin ex_res = ex_a | ex_b; ex_wr = 1'b1; end
      OP_XOR:  begin ex_res = ex_a ^ ex_b; ex_wr = 1'b1; end
      OP_SHL:  begin ex_res = (int'(sh_amt) >= DW) ? '0 : ex_a << sh_amt; ex_wr = 1'b1; end
      OP_SHR:  begin ex_res = (int'(sh_amt) >= DW) ? '0 : ex_a >> sh_amt; ex_wr = 1'b1; end
      OP_LI:   begin ex_res = DW'($signed(ex_imm)); ex_wr = 1'b1; end
      OP_LD:   begin ex_res = dmem_rdata; ex_wr = 1'b1; end
      OP_BEQZ: take_br = (ex_c == '0);
      OP_JMP:  take_br = 1'b1;
      OP_HALT: ex_halt = 1'b1;
      default: ;
    endcase
    if (ex_rd == 4'd0) ex_wr = 1'b0;   // r0 is hard-wired to zero
  end

  // Newest producer wins: EX result, then WB result, then the register file.
  function automatic logic [DW-1:0] fwd(
    input logic [3:0]    idx,
    input logic [DW-1:0] rf_val,
    input logic          ex_wr_i,
    input logic [3:0]    ex_rd_i,
    input logic [DW-1:0] ex_res_i,
    input logic          wb_we_i,
    input logic [3:0]    wb_rd_i,
    input logic [DW-1:0] wb_val_i
  );
    if (ex_wr_i && ex_rd_i == idx)      return ex_res_i;
    else if (wb_we_i && wb_rd_i == idx) return wb_val_i;
    else                                return rf_val;
  endfunction

  assign dc_a = fwd(dc_ir[7:4],  rf[dc_ir[7:4]],  ex_wr, ex_rd, ex_res, wb_we, wb_rd, wb_val);
  assign dc_b = fwd(dc_ir[3:0],  rf[dc_ir[3:0]],  ex_wr, ex_rd, ex_res, wb_we, wb_rd, wb_val);
  assign dc_c = fwd(dc_ir[11:8], rf[dc_ir[11:8]], ex_wr, ex_rd, ex_res, wb_we, wb_rd, wb_val);

  assign flush = take_br | ex_halt | halted_q;

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every stage samples the pre-edge values of the stage before it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      halted_q <= 1'b0;
      dc_ir    <= '0;
      ex_op    <= OP_NOP;
      ex_rd    <= '0;
      ex_imm   <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_c     <= '0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_val   <= '0;
      // NOTE: the register file is reset explicitly because software relies
      // on all registers reading zero after reset.
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (!stall_in) begin
      if (take_br)                      pc <= IAW'(ex_imm);
      else if (!(ex_halt || halted_q))  pc <= pc + 1'b1;

      if (ex_halt) halted_q <= 1'b1;

      dc_ir  <= flush ? 16'h0000 : imem_data;

      ex_op  <= flush ? OP_NOP : op_e'(dc_ir[15:12]);
      ex_rd  <= dc_ir[11:8];
      ex_imm <= dc_ir[7:0];
      ex_a   <= dc_a;
      ex_b   <= dc_b;
      ex_c   <= dc_c;

      wb_we  <= ex_wr;
      wb_rd  <= ex_rd;
      wb_val <= ex_res;

      if (wb_we) rf[wb_rd] <= wb_val;
    end
  end

  assign imem_addr  = pc;
  assign dbg_pc     = pc;
  assign halted     = halted_q;
  assign dmem_addr  = DAW'(ex_a);
  assign dmem_wdata = ex_c;
  assign dmem_we    = (ex_op == OP_ST) && !stall_in && !rst;

endmodule

// File: tb/tb_pipe_cpu.sv
`timescale 1ns/1ps
// tb_pipe_cpu: directed programs with hand-computed results for pipe_cpu,
// observing the fetch PC, data-memory strobes and the register file.
module tb_pipe_cpu;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic [7:0]  imem_addr, dmem_addr, dbg_pc;
  logic [15:0] imem_data, dmem_wdata, dmem_rdata;
  logic        dmem_we, halted;

  logic [15:0] imem [256];
  logic [15:0] dmem [256] = '{default: '0};

  int n_run  = 0;
  int n_fail = 0;

  int          we_count;
  logic [7:0]  we_addr;
  logic [15:0] we_data;

  pipe_cpu #(.DW(16), .IAW(8), .DAW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_rdata (dmem_rdata),
    .stall_in   (stall_in),
    .halted     (halted),
    .dbg_pc     (dbg_pc)
  );

  always #5 clk = ~clk;

  assign imem_data  = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) if (dmem_we) dmem[dmem_addr] <= dmem_wdata;

  // Store-strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) we_count <= 0;
    else if (dmem_we) begin
      we_count <= we_count + 1;
      we_addr  <= dmem_addr;
      we_data  <= dmem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  // Leaves the bench 1 ns into cycle 1, where address 0 is being fetched.
  task automatic reset_cpu();
    rst      = 1'b1;
    stall_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    stall_in = 1'b0;

    // Reset state
    clear_imem();
    reset_cpu();
    check("rst_pc",      dbg_pc,     8'h00);
    check("rst_imem",    imem_addr,  8'h00);
    check("rst_halted",  halted,     1'b0);
    check("rst_we",      dmem_we,    1'b0);

    // Back-to-back forwarding: r3 written at the end of cycle 6
    clear_imem();
    imem[0] = 16'h8105;  // LI r1,5
    imem[1] = 16'h8203;  // LI r2,3
    imem[2] = 16'h1312;  // ADD r3,r1,r2
    reset_cpu();
    check("fwd_pc_c1", dbg_pc, 8'h00);
    step(1);
    check("fwd_pc_c2", dbg_pc, 8'h01);
    step(4);
    check("fwd_r1",        dut.rf[1], 16'h0005);
    check("fwd_r3_before", dut.rf[3], 16'h0000);
    step(1);
    check("fwd_r3", dut.rf[3], 16'h0008);

    // Store / load / use
    clear_imem();
    imem[0] = 16'h8110;  // LI r1,0x10
    imem[1] = 16'h827F;  // LI r2,0x7F
    imem[2] = 16'hA210;  // ST r2 -> [r1]
    imem[3] = 16'h9410;  // LD r4,[r1]
    imem[4] = 16'h1544;  // ADD r5,r4,r4
    reset_cpu();
    step(12);
    check("st_count", we_count,   1);
    check("st_addr",  we_addr,    8'h10);
    check("st_data",  we_data,    16'h007F);
    check("st_mem",   dmem[16],   16'h007F);
    check("ld_r4",    dut.rf[4],  16'h007F);
    check("ld_r5",    dut.rf[5],  16'h00FE);

    // Taken and not-taken BEQZ
    clear_imem();
    imem[0]     = 16'h8100;  // LI r1,0
    imem[1]     = 16'hB120;  // BEQZ r1,0x20
    imem[2]     = 16'h8601;  // LI r6,1  (flushed)
    imem[3]     = 16'h8701;  // LI r7,1  (flushed)
    imem[8'h20] = 16'h8833;  // LI r8,0x33
    imem[8'h21] = 16'hB840;  // BEQZ r8,0x40 (not taken)
    imem[8'h22] = 16'h8902;  // LI r9,2
    reset_cpu();
    step(3);
    check("br_pc_pre",    dbg_pc, 8'h03);
    step(1);
    check("br_pc_target", dbg_pc, 8'h20);
    step(4);
    check("br_nt_pc",     dbg_pc, 8'h24);
    step(6);
    check("br_r6_flushed", dut.rf[6], 16'h0000);
    check("br_r7_flushed", dut.rf[7], 16'h0000);
    check("br_r8",         dut.rf[8], 16'h0033);
    check("br_r9",         dut.rf[9], 16'h0002);

    // Three-cycle stall with a store in EX
    clear_imem();
    imem[0] = 16'h8101;  // LI r1,1
    imem[1] = 16'h8202;  // LI r2,2
    imem[2] = 16'h1312;  // ADD r3,r1,r2
    imem[3] = 16'hA310;  // ST r3 -> [r1]
    imem[4] = 16'h1433;  // ADD r4,r3,r3
    imem[5] = 16'h2541;  // SUB r5,r4,r1
    imem[6] = 16'h5654;  // XOR r6,r5,r4
    reset_cpu();
    step(5);
    stall_in = 1'b1;
    #1;
    check("stall_we_c6", dmem_we, 1'b0);
    check("stall_pc_c6", dbg_pc,  8'h05);
    for (int i = 0; i < 2; i++) begin
      step(1);
      check("stall_we", dmem_we, 1'b0);
      check("stall_pc", dbg_pc,  8'h05);
    end
    check("stall_rf_hold", dut.rf[3], 16'h0000);
    step(1);
    stall_in = 1'b0;
    #1;
    check("unstall_we",   dmem_we,   1'b1);
    check("unstall_addr", dmem_addr, 8'h01);
    check("unstall_pc",   dbg_pc,    8'h05);
    step(12);
    check("stall_r3",    dut.rf[3], 16'h0003);
    check("stall_r4",    dut.rf[4], 16'h0006);
    check("stall_r5",    dut.rf[5], 16'h0005);
    check("stall_r6",    dut.rf[6], 16'h0003);
    check("stall_mem",   dmem[1],   16'h0003);
    check("stall_count", we_count,  1);

    // HALT at 0x04, then reset mid-run
    clear_imem();
    imem[0] = 16'h8107;  // LI r1,7
    imem[3] = 16'h8404;  // LI r4,4 (in WB when HALT is in EX)
    imem[4] = 16'hF000;  // HALT
    imem[5] = 16'h8209;  // LI r2,9 (flushed)
    imem[6] = 16'h8309;  // LI r3,9 (flushed)
    reset_cpu();
    step(6);
    check("halt_pre",     halted, 1'b0);
    check("halt_pc_pre",  dbg_pc, 8'h06);
    step(1);
    check("halt_set",     halted, 1'b1);
    check("halt_pc",      dbg_pc, 8'h06);
    step(5);
    check("halt_sticky",  halted, 1'b1);
    check("halt_pc_hold", dbg_pc, 8'h06);
    check("halt_r1",      dut.rf[1], 16'h0007);
    check("halt_r4",      dut.rf[4], 16'h0004);
    check("halt_r2",      dut.rf[2], 16'h0000);
    check("halt_r3",      dut.rf[3], 16'h0000);
    reset_cpu();
    check("rerst_pc",     dbg_pc,    8'h00);
    check("rerst_halted", halted,    1'b0);
    check("rerst_r1",     dut.rf[1], 16'h0000);
    check("rerst_r4",     dut.rf[4], 16'h0000);

    // ALU ops, sign extension, shift-amount masking, JMP, reserved opcodes
    clear_imem();
    imem[0]     = 16'h8185;  // LI r1,0x85 -> 0xFF85
    imem[1]     = 16'h8204;  // LI r2,4
    imem[2]     = 16'h6312;  // SHL r3,r1,r2
    imem[3]     = 16'h7412;  // SHR r4,r1,r2
    imem[4]     = 16'h3512;  // AND r5,r1,r2
    imem[5]     = 16'h4612;  // OR  r6,r1,r2
    imem[6]     = 16'h2721;  // SUB r7,r2,r1
    imem[7]     = 16'h8811;  // LI r8,0x11
    imem[8]     = 16'h6928;  // SHL r9,r2,r8 (amount 1)
    imem[9]     = 16'hC030;  // JMP 0x30
    imem[10]    = 16'h8A01;  // LI r10,1 (flushed)
    imem[11]    = 16'h8A02;  // LI r10,2 (flushed)
    imem[8'h30] = 16'hD1FF;  // reserved: no effect
    imem[8'h31] = 16'hE1FF;  // reserved: no effect
    imem[8'h32] = 16'h8B2A;  // LI r11,0x2A
    reset_cpu();
    step(20);
    check("alu_li_sext", dut.rf[1],  16'hFF85);
    check("alu_shl",     dut.rf[3],  16'hF850);
    check("alu_shr",     dut.rf[4],  16'h0FF8);
    check("alu_and",     dut.rf[5],  16'h0004);
    check("alu_or",      dut.rf[6],  16'hFF85);
    check("alu_sub",     dut.rf[7],  16'h007F);
    check("alu_shmask",  dut.rf[9],  16'h0008);
    check("jmp_flush",   dut.rf[10], 16'h0000);
    check("jmp_target",  dut.rf[11], 16'h002A);

    // PC wrap and r0 hard-wired to zero
    clear_imem();
    imem[0] = 16'h8105;  // LI r1,5
    imem[1] = 16'h8009;  // LI r0,9 (discarded)
    imem[2] = 16'h1100;  // ADD r1,r0,r0
    reset_cpu();
    step(255);
    check("wrap_pc_ff", dbg_pc,    8'hFF);
    step(1);
    check("wrap_pc_00", dbg_pc,    8'h00);
    check("r0_zero",    dut.rf[0], 16'h0000);
    check("r0_add",     dut.rf[1], 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_cpu.md
PIPE_CPU -- requirements
Module: pipe_cpu

Interface
REQ-001 Parameter DW, default 16, data/register width (>= 8).
REQ-002 Parameter IAW, default 8, instruction address width.
REQ-003 Parameter DAW, default 8, data address width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 imem_addr  output  IAW  fetch PC.
REQ-007 imem_data  input  16  instruction at imem_addr, combinational same cycle.
REQ-008 dmem_addr  output  DAW  data address, low DAW bits of r[rs].
REQ-009 dmem_wdata  output  DW  store data.
REQ-010 dmem_we  output  1  store strobe, one cycle per ST.
REQ-011 dmem_rdata  input  DW  load data for dmem_addr, combinational.
REQ-012 stall_in  input  1  freeze whole pipeline while high.
REQ-013 halted  output  1  sticky; HALT has retired from EX.
REQ-014 dbg_pc  output  IAW  current PC, equal to imem_addr.

Function
REQ-015 Single-clock four-stage pipeline FE -> DC -> EX -> WB; one instruction issued per cycle, no phase clocks.
REQ-016 Format: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt, imm8 = [7:0]; 16 registers of DW bits; r0 reads 0, writes to r0 discarded.
REQ-017 Ops: 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR; 6 SHL rd=rs<<rt[3:0]; 7 SHR logical; 8 LI rd=sext(imm8); 9 LD rd=mem[rs]; A ST mem[rs]=r[rd]; B BEQZ if r[rd]==0 pc=imm8; C JMP pc=imm8; F HALT; D,E execute as NOP.
REQ-018 Arithmetic modulo 2^DW, no flags; shift amounts >= DW give 0; branch targets zero-extended/truncated to IAW.
REQ-019 PC increments by 1 per fetch, wrapping 2^IAW-1 -> 0.
REQ-020 Register read in DC; operand priority: EX-stage result, then WB-stage result, then register file; newest producer wins.
REQ-021 LD data taken from dmem_rdata in EX and forwarded like ALU results; no load-use stall.
REQ-022 ST, BEQZ, JMP, HALT, NOP write no register; ST asserts dmem_we only while in EX.
REQ-023 Branch/jump resolved in EX: if taken, PC <= target next edge, FE and DC contents replaced by NOP (2-cycle penalty); not-taken costs nothing.
REQ-024 HALT in EX: PC frozen, FE/DC flushed, halted=1 from next cycle; instruction in WB still retires; sticky until rst.
REQ-025 stall_in=1: PC, pipeline registers and register file hold; dmem_we forced 0; EX-stage branch/HALT not acted on until stall_in=0.
REQ-026 Branch and HALT in EX same cycle impossible; taken branch in EX while HALT in DC: HALT flushed.
REQ-027 Register-file write occurs at end of WB; same-cycle DC read of that register sees new value.

Reset
REQ-028 rst=1 at an edge: PC=0, all stage registers NOP, all registers 0, halted=0, dmem_we=0; overrides stall_in and in-flight instructions.
REQ-029 Release: first fetch from address 0 in the cycle after rst deasserts; first writeback 3 cycles later.

Verification
REQ-030 LI r1,5; LI r2,3; ADD r3,r1,r2 back-to-back -> r3=8 via forwarding, no bubble, retires cycle 6 after reset release.
REQ-031 LI r1,0x10; ST r2->[r1] after LI r2,0x7F; LD r4,[r1]; ADD r5,r4,r4 -> dmem_we one cycle at addr 0x10 data 0x7F; r5=0xFE.
REQ-032 LI r1,0; BEQZ r1,0x20; two following LI r6,1 / LI r7,1 -> both flushed (r6=r7=0), next fetch 0x20.
REQ-033 stall_in high 3 cycles mid ADD chain -> dbg_pc constant, dmem_we 0, final results identical to unstalled run.
REQ-034 HALT at 0x04 -> halted=1 two cycles after HALT fetched plus one, dbg_pc frozen; rst mid-run -> PC=0, regs 0, halted 0.
REQ-035 PC at 0xFF (IAW=8) with NOPs -> next fetch 0x00; LI r0,9 then ADD r1,r0,r0 -> r1=0.
